teste_s01_axi_burst_mem: RTL

AXI4 full-protocol burst slave backed by an internal word-addressed memory. It is the S01_AXI endpoint of the teste IP that the master VIP drives with INCR/FIXED/WRAP bursts. Independent write and read engines, one outstanding transaction per direction, ID echo, byte strobes. Lock/cache/prot/qos/region/user signals are tied off at the IP boundary and are not ports.

---
 rtl/teste_s01_axi_burst_mem.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/teste_s01_axi_burst_mem.sv
// teste S01_AXI burst slave: AXI4 INCR/FIXED/WRAP bursts
// into a word-addressed memory, one transaction per direction.
module teste_s01_axi_burst_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int IW    = C_S_AXI_ID_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << (AW - 2);

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LOAD,
    R_DATA
  } r_state_t;

  function automatic logic [AW-1:0] next_addr(
    input logic [AW-1:0] a,
    input logic [7:0]    len,
    input logic [1:0]    burst
  );
    logic [AW-1:0] mask;
    logic [AW-1:0] inc;
    mask = AW'({len, 2'b11});
    inc  = a + AW'(4);
    unique case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | (inc & mask);
      default: next_addr = inc;
    endcase
  endfunction

  function automatic logic bad_cmd(
    input logic [2:0] size,
    input logic [1:0] burst,
    input logic [7:0] len
  );
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) ||
              (len == 8'd7) || (len == 8'd15);
    bad_cmd = (size != 3'd2) || (burst == 2'b11) ||
              ((burst == 2'b10) && !wrap_ok);
  endfunction

  logic [DW-1:0] mem [DEPTH];

  logic          rst_done;

  w_state_t      w_state;
  w_state_t      w_next;
  logic [IW-1:0] w_id;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_len;
  logic [1:0]    w_burst;
  logic [8:0]    w_cnt;
  logic          w_err;
  logic [1:0]    b_resp;
  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;
  logic          w_keep;

  r_state_t      r_state;
  r_state_t      r_next;
  logic [IW-1:0] r_id;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_nxt;
  logic [7:0]    r_len;
  logic [1:0]    r_burst;
  logic [7:0]    r_cnt;
  logic          r_err;
  logic [DW-1:0] r_data;
  logic          r_last;
  logic          ar_hs;
  logic          r_hs;

  // Hold address readies low for one cycle after reset
  always_ff @(posedge ACLK) begin
    if (!ARESETN) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  // Write FSM state register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  // Write FSM next state and handshake outputs
  always_comb begin
    w_next        = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = rst_done;
        if (S_AXI_AWVALID && rst_done) w_next = W_DATA;
      end
      W_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID && S_AXI_WLAST) w_next = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs        = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs        = S_AXI_BVALID && S_AXI_BREADY;
  assign w_keep      = !w_err && (w_cnt <= {1'b0, w_len});
  assign S_AXI_BID   = w_id;
  assign S_AXI_BRESP = b_resp;

  // Write command latch, beat walk and response code
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      b_resp  <= '0;
    end else begin
      if (aw_hs) begin
        w_id    <= S_AXI_AWID;
        w_addr  <= S_AXI_AWADDR;
        w_len   <= S_AXI_AWLEN;
        w_burst <= S_AXI_AWBURST;
        w_cnt   <= '0;
        w_err   <= bad_cmd(S_AXI_AWSIZE, S_AXI_AWBURST,
                           S_AXI_AWLEN);
      end
      if (w_hs) begin
        w_addr <= next_addr(w_addr, w_len, w_burst);
        if (w_cnt <= {1'b0, w_len}) w_cnt <= w_cnt + 9'd1;
        if (S_AXI_WLAST)
          b_resp <= (w_err || (w_cnt != {1'b0, w_len})) ?
                    2'b10 : 2'b00;
      end
    end
  end

  // Byte-strobed memory write; surplus beats are dropped
  always_ff @(posedge ACLK) begin
    if (ARESETN && w_hs && w_keep) begin
      for (int b = 0; b < NB; b++) begin
        if (S_AXI_WSTRB[b])
          mem[w_addr[AW-1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  // Read FSM next state and handshake outputs
  always_comb begin
    r_next        = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = rst_done;
        if (S_AXI_ARVALID && rst_done) r_next = R_LOAD;
      end
      R_LOAD: r_next = R_DATA;
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY && r_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_hs        = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs         = S_AXI_RVALID && S_AXI_RREADY;
  assign r_last       = (r_state == R_DATA) && (r_cnt == r_len);
  assign r_nxt        = next_addr(r_addr, r_len, r_burst);
  assign S_AXI_RID    = r_id;
  assign S_AXI_RDATA  = r_data;
  assign S_AXI_RLAST  = r_last;
  assign S_AXI_RRESP  = ((r_state == R_DATA) && r_err) ?
                        2'b10 : 2'b00;

  // Read command latch and prefetch of each beat's data
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_data  <= '0;
    end else begin
      if (ar_hs) begin
        r_id    <= S_AXI_ARID;
        r_addr  <= S_AXI_ARADDR;
        r_len   <= S_AXI_ARLEN;
        r_burst <= S_AXI_ARBURST;
        r_cnt   <= '0;
        r_err   <= bad_cmd(S_AXI_ARSIZE, S_AXI_ARBURST,
                           S_AXI_ARLEN);
      end
      if (r_state == R_LOAD)
        r_data <= r_err ? '0 : mem[r_addr[AW-1:2]];
      if (r_hs && !r_last) begin
        r_addr <= r_nxt;
        r_cnt  <= r_cnt + 8'd1;
        r_data <= r_err ? '0 : mem[r_nxt[AW-1:2]];
      end
    end
  end

endmodule
